ps2_key_decoder: RTL

- Sits directly downstream of ps2_keyboard.
- Pops bytes from the keyboard's receive FIFO through its ready/nextdata_n handshake.
- Parses the PS/2 set-2 prefixes E0 (extended) and F0 (break), and tracks the currently held key.
- Outputs last scan code, ASCII, press count and key-down status for the seg display and LED logic.

---
 rtl/ps2_key_decoder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// Purpose:
//   Pops bytes from the ps2_keyboard receive FIFO one at a time and decodes
//   the PS/2 scan-code set 2 byte stream. E0 (extended) and F0 (break)
//   prefixes are tracked so that each make code can be told apart from a
//   release or a typematic repeat. The block presents the most recent make
//   code together with its ASCII value, a one-cycle pulse for every new
//   press, a running press counter and a held-key indicator.
//
// Ports:
//   clk            in   system clock, shared with ps2_keyboard
//   resetn         in   asynchronous active-low reset
//   kb_data[7:0]   in   FIFO head byte from ps2_keyboard
//   kb_ready       in   FIFO non-empty flag from ps2_keyboard
//   kb_nextdata_n  out  active-low pop strobe back to ps2_keyboard
//   scan_code[7:0] out  low byte of the last new make code
//   ext            out  last new make code carried an E0 prefix
//   ascii[7:0]     out  ASCII of scan_code (0x00 if unmapped or extended)
//   key_down       out  a key is currently held
//   key_valid      out  one-cycle pulse per new press (not on repeats)
//   key_count      out  new presses since reset, wraps modulo 2^COUNT_W
//
// Parameters:
//   COUNT_W        width of key_count
//
// Build options:
//   PS2_SHIFT_EN   when defined, left/right shift (0x12 / 0x59) are tracked
//                  as a modifier and select uppercase letters; when not
//                  defined they behave like any other key.
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         kb_data,
  input  logic               kb_ready,
  output logic               kb_nextdata_n,
  output logic [7:0]         scan_code,
  output logic               ext,
  output logic [7:0]         ascii,
  output logic               key_down,
  output logic               key_valid,
  output logic [COUNT_W-1:0] key_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        load_byte;
  logic        process_byte;

  logic [7:0]  byte_r;
  logic        ext_pend;
  logic        brk_pend;
  logic [8:0]  held_code;

  logic        is_err;
  logic        is_e0;
  logic        is_f0;
  logic        plain;
  logic        is_shift;
  logic        upper;
  logic        code_match;
  logic        new_press;
  logic        release_hit;

  // ASCII lookup for set-2 make codes. Letters come back lowercase unless
  // the upper flag is set; digits and space ignore it.
  function automatic logic [7:0] ascii_lookup(input logic [7:0] code,
                                              input logic       up);
    logic [7:0] letter;
    logic [7:0] other;
    letter = 8'h00;
    other  = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; // a
      8'h32: letter = 8'h62; // b
      8'h21: letter = 8'h63; // c
      8'h23: letter = 8'h64; // d
      8'h24: letter = 8'h65; // e
      8'h2B: letter = 8'h66; // f
      8'h34: letter = 8'h67; // g
      8'h33: letter = 8'h68; // h
      8'h43: letter = 8'h69; // i
      8'h3B: letter = 8'h6A; // j
      8'h42: letter = 8'h6B; // k
      8'h4B: letter = 8'h6C; // l
      8'h3A: letter = 8'h6D; // m
      8'h31: letter = 8'h6E; // n
      8'h44: letter = 8'h6F; // o
      8'h4D: letter = 8'h70; // p
      8'h15: letter = 8'h71; // q
      8'h2D: letter = 8'h72; // r
      8'h1B: letter = 8'h73; // s
      8'h2C: letter = 8'h74; // t
      8'h3C: letter = 8'h75; // u
      8'h2A: letter = 8'h76; // v
      8'h1D: letter = 8'h77; // w
      8'h22: letter = 8'h78; // x
      8'h35: letter = 8'h79; // y
      8'h1A: letter = 8'h7A; // z
      8'h45: other  = 8'h30; // 0
      8'h16: other  = 8'h31; // 1
      8'h1E: other  = 8'h32; // 2
      8'h26: other  = 8'h33; // 3
      8'h25: other  = 8'h34; // 4
      8'h2E: other  = 8'h35; // 5
      8'h36: other  = 8'h36; // 6
      8'h3D: other  = 8'h37; // 7
      8'h3E: other  = 8'h38; // 8
      8'h46: other  = 8'h39; // 9
      8'h29: other  = 8'h20; // space
      default: begin
        letter = 8'h00;
        other  = 8'h00;
      end
    endcase
    if (letter != 8'h00) begin
      return up ? (letter - 8'h20) : letter;
    end
    return other;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: one byte takes IDLE -> POP -> WAIT, so the FIFO read
  // pointer and kb_ready have a full cycle to settle after each pop.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (kb_ready) state_next = ST_POP;
      ST_POP:  state_next = ST_WAIT;
      ST_WAIT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: the pop strobe is decoded from the state alone, so it can
  // only ever be low for the single POP cycle.
  always_comb begin
    kb_nextdata_n = 1'b1;
    load_byte     = 1'b0;
    process_byte  = 1'b0;
    case (state)
      ST_IDLE: load_byte     = kb_ready;
      ST_POP:  kb_nextdata_n = 1'b0;
      ST_WAIT: process_byte  = 1'b1;
      default: kb_nextdata_n = 1'b1;
    endcase
  end

`ifdef PS2_SHIFT_EN
  logic shift_held;

  // Only the non-extended codes count as shift; E0 12 appears inside the
  // print-screen sequence and must not latch the modifier.
  assign is_shift = !ext_pend && ((byte_r == 8'h12) || (byte_r == 8'h59));
  assign upper    = shift_held;

  // Shift make sets the modifier, shift break clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_held <= 1'b0;
    end else if (process_byte && plain && is_shift) begin
      shift_held <= !brk_pend;
    end
  end
`else
  assign is_shift = 1'b0;
  assign upper    = 1'b0;
`endif

  // Byte classification for the WAIT cycle. A plain byte is anything that
  // is not an error marker or a prefix; its meaning depends on the pending
  // prefixes and on the currently held code.
  always_comb begin
    is_err      = (byte_r == 8'h00) || (byte_r == 8'hFF);
    is_e0       = (byte_r == 8'hE0);
    is_f0       = (byte_r == 8'hF0);
    plain       = !is_err && !is_e0 && !is_f0;
    code_match  = key_down && (held_code == {ext_pend, byte_r});
    new_press   = process_byte && plain && !is_shift && !brk_pend && !code_match;
    release_hit = process_byte && plain && !is_shift &&  brk_pend &&  code_match;
  end

  // Datapath: prefix flags, held code and all registered outputs. A break
  // of a key other than the held one leaves key_down untouched, which is
  // how a second key pressed over the first takes over the held slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_r    <= 8'h00;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      held_code <= 9'h000;
      scan_code <= 8'h00;
      ext       <= 1'b0;
      ascii     <= 8'h00;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
      key_count <= '0;
    end else begin
      key_valid <= new_press;

      if (load_byte) begin
        byte_r <= kb_data;
      end

      if (process_byte) begin
        if (is_e0) begin
          ext_pend <= 1'b1;
        end else if (is_f0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end

      if (release_hit) begin
        key_down <= 1'b0;
      end

      if (new_press) begin
        held_code <= {ext_pend, byte_r};
        scan_code <= byte_r;
        ext       <= ext_pend;
        ascii     <= ext_pend ? 8'h00 : ascii_lookup(byte_r, upper);
        key_down  <= 1'b1;
        key_count <= key_count + 1'b1;
      end
    end
  end

endmodule
